// File: rtl/bingo_pkg.sv
// Shared constants, FSM state type and line masks for the bingo board tracker.
package bingo_pkg;

  localparam int N_CELLS = 25;
  localparam int N_LINES = 12;
  localparam int CELL_W  = 5;

  localparam logic [4:0] LAST_CELL = 5'd24;
  localparam logic [3:0] LAST_LINE = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Rows 0..4, columns 5..9, main diagonal 10, anti-diagonal 11.
  localparam logic [24:0] LINE_MASK [0:11] = '{
    25'h000001F,  // row 0: cells 0..4
    25'h00003E0,  // row 1: cells 5..9
    25'h0007C00,  // row 2: cells 10..14
    25'h00F8000,  // row 3: cells 15..19
    25'h1F00000,  // row 4: cells 20..24
    25'h0108421,  // col 0: cells 0,5,10,15,20
    25'h0210842,  // col 1
    25'h0421084,  // col 2
    25'h0842108,  // col 3
    25'h1084210,  // col 4
    25'h1041041,  // diagonal: 0,6,12,18,24
    25'h0111110   // anti-diagonal: 4,8,12,16,20
  };

endpackage

// File: rtl/bcd2_from_bin.sv
// Combinational binary (0..12) to two-digit BCD {tens, ones}.
module bcd2_from_bin (
  input  logic [3:0] bin,
  output logic [7:0] bcd
);

  // Split the line count into tens and ones digits.
  always_comb begin
    bcd = 8'h00;
    if (bin >= 4'd10) begin
      bcd = {4'd1, bin - 4'd10};
    end else begin
      bcd = {4'd0, bin};
    end
  end

endmodule

// File: rtl/bingo_board_tracker.sv
// Tracks marked cells of one 5x5 bingo board: scans the board for each called
// number, recounts completed lines and publishes the count as BCD digits.
module bingo_board_tracker
  import bingo_pkg::*;
#(
  parameter int WIN_LINES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [124:0] map,
  input  logic         num_valid,
  input  logic [4:0]   num,
  output logic         num_ready,
  output logic [24:0]  circle,
  output logic [3:0]   lines,
  output logic [7:0]   display_nums,
  output logic         win,
  output logic         done
);

  localparam logic [3:0] WIN_THR = WIN_LINES[3:0];

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  line_q, line_d;
  logic [3:0]  acc_q, acc_d;
  logic [4:0]  num_q, num_d;
  logic [24:0] circle_q, circle_d;
  logic [3:0]  lines_q, lines_d;
  logic [7:0]  disp_q, disp_d;
  logic        win_q, win_d;
  logic        done_q, done_d;

  logic [4:0]  cell_val_s;
  logic        line_hit_s;
  logic [3:0]  sum_s;
  logic [7:0]  sum_bcd_s;

  assign cell_val_s = map[idx_q*CELL_W +: CELL_W];
  assign line_hit_s = ((circle_q & LINE_MASK[line_q]) == LINE_MASK[line_q]);
  assign sum_s      = acc_q + {3'b000, line_hit_s};

  bcd2_from_bin u_bcd (
    .bin (sum_s),
    .bcd (sum_bcd_s)
  );

  // Next-state and datapath update; clear overrides everything, including an accept.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    line_d   = line_q;
    acc_d    = acc_q;
    num_d    = num_q;
    circle_d = circle_q;
    lines_d  = lines_q;
    disp_d   = disp_q;
    win_d    = win_q;
    done_d   = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      idx_d    = 5'd0;
      line_d   = 4'd0;
      acc_d    = 4'd0;
      circle_d = 25'd0;
      lines_d  = 4'd0;
      disp_d   = 8'h00;
      win_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (num_valid) begin
            num_d   = num;
            idx_d   = 5'd0;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          // Marks are only ever added here, never removed.
          if (cell_val_s == num_q) begin
            circle_d[idx_q] = 1'b1;
          end else begin
            circle_d = circle_q;
          end
          if (idx_q == LAST_CELL) begin
            idx_d   = 5'd0;
            line_d  = 4'd0;
            acc_d   = 4'd0;
            state_d = ST_COUNT;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        ST_COUNT: begin
          if (line_q == LAST_LINE) begin
            // Last line folds directly into the published outputs.
            lines_d = sum_s;
            disp_d  = sum_bcd_s;
            win_d   = (sum_s >= WIN_THR);
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d  = sum_s;
            line_d = line_q + 4'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 5'd0;
      line_q   <= 4'd0;
      acc_q    <= 4'd0;
      num_q    <= 5'd0;
      circle_q <= 25'd0;
      lines_q  <= 4'd0;
      disp_q   <= 8'h00;
      win_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      line_q   <= line_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      circle_q <= circle_d;
      lines_q  <= lines_d;
      disp_q   <= disp_d;
      win_q    <= win_d;
      done_q   <= done_d;
    end
  end

  assign num_ready    = (state_q == ST_IDLE);
  assign circle       = circle_q;
  assign lines        = lines_q;
  assign display_nums = disp_q;
  assign win          = win_q;
  assign done         = done_q;

endmodule
